// File: rtl/pixel_filter_pkg.sv
// Shared types and helpers for the pixel filter chain.
// Provides the blend mode enum and the BPM-to-brightness target mapping.
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        BLEND_BYPASS  = 2'd0,
        BLEND_AVG     = 2'd1,
        BLEND_SAT_ADD = 2'd2,
        BLEND_GAIN    = 2'd3
    } blend_mode_e;

    // Target brightness for a BPM estimate. The product is formed at
    // 64 bits so nothing is truncated before the Q8 shift.
    function automatic int unsigned bpm_to_brightness(
        input int unsigned bpm,
        input int unsigned max_bpm,
        input int unsigned step_size,
        input int unsigned bits
    );
        longint unsigned b;
        longint unsigned prod;
        longint unsigned t;
        longint unsigned m;
        b    = (bpm > max_bpm) ? 64'(max_bpm) : 64'(bpm);
        prod = 64'(step_size) * b;
        t    = prod >> 8;
        m    = (64'd1 << bits) - 64'd1;
        if (t > m) t = m;
        return 32'(t);
    endfunction

endpackage

// File: rtl/brightness_filter_pipe_blend.sv
// pixel_blend: combinational blend of one component with a brightness.
// Ports: p_i component, b_i brightness, mode_i blend mode, out_o result.
module pixel_blend
    import pixel_filter_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] p_i,
    input  logic [BITS-1:0] b_i,
    input  blend_mode_e     mode_i,
    output logic [BITS-1:0] out_o
);

    localparam int unsigned PW = 2 * BITS + 1;

    logic [BITS:0]   sum;
    logic [PW-1:0]   prod;
    logic [BITS:0]   gain;

    assign sum  = {1'b0, p_i} + {1'b0, b_i};
    // {1'b1, b} is 2^BITS + b, i.e. a gain of 1 + b/2^BITS.
    assign prod = PW'(p_i) * PW'({1'b1, b_i});
    assign gain = prod[2*BITS:BITS];

    always_comb begin
        out_o = p_i;
        unique case (mode_i)
            BLEND_BYPASS:  out_o = p_i;
            BLEND_AVG:     out_o = sum[BITS:1];
            BLEND_SAT_ADD: out_o = sum[BITS] ? '1 : sum[BITS-1:0];
            BLEND_GAIN:    out_o = gain[BITS] ? '1 : gain[BITS-1:0];
            default:       out_o = p_i;
        endcase
    end

endmodule

// File: rtl/brightness_filter_pipe.sv
// brightness_filter_pipe: BPM-driven brightness blend, 2-stage valid/ready.
// Ports: pix_in/sof_in/valid_in/module_ready in, pix_out/sof_out/valid_out/
// output_ready out, filter_enable/mode/BPM_estimate controls, brightness.
module brightness_filter_pipe
    import pixel_filter_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned MAX_BPM   = 200,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned STEP_SIZE = ((1 << BITS) << 8) / MAX_BPM,
    parameter int unsigned BW        = $clog2(MAX_BPM + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] pix_in,
    input  logic                     sof_in,
    input  logic                     valid_in,
    output logic                     module_ready,
    input  logic                     filter_enable,
    input  logic [1:0]               mode,
    input  logic [BW-1:0]            BPM_estimate,
    output logic [CHANNELS*BITS-1:0] pix_out,
    output logic                     sof_out,
    output logic                     valid_out,
    input  logic                     output_ready,
    output logic [BITS-1:0]          brightness
);

    localparam int unsigned PW = CHANNELS * BITS;

    logic [BITS-1:0] bright_q, bright_d;
    blend_mode_e     mode_q, mode_d;
    logic            en_q, en_d;

    logic            s1_v_q;
    logic [PW-1:0]   s1_pix_q;
    logic            s1_sof_q;
    logic [BITS-1:0] s1_b_q, s1_b_d;
    blend_mode_e     s1_mode_q, s1_mode_d;

    logic            s2_v_q;
    logic [PW-1:0]   s2_pix_q;
    logic            s2_sof_q;

    logic [BITS-1:0] target;
    logic [BITS-1:0] slew_b;
    logic [BITS-1:0] diff;
    logic [PW-1:0]   blend_pix;
    logic            s1_free, s2_free, acc, sof_acc;
    logic            sel_en;
    blend_mode_e     sel_mode;

    assign target = BITS'(bpm_to_brightness(32'(BPM_estimate), MAX_BPM,
                                            STEP_SIZE, BITS));

    // One bounded step toward target; never overshoots.
    always_comb begin
        slew_b = bright_q;
        diff   = '0;
        if (target > bright_q) begin
            diff   = target - bright_q;
            slew_b = bright_q + ((32'(diff) > RAMP_STEP)
                                 ? BITS'(RAMP_STEP) : diff);
        end else if (target < bright_q) begin
            diff   = bright_q - target;
            slew_b = bright_q - ((32'(diff) > RAMP_STEP)
                                 ? BITS'(RAMP_STEP) : diff);
        end
    end

    assign s2_free      = !s2_v_q || output_ready;
    assign s1_free      = !s1_v_q || s2_free;
    assign module_ready = s1_free;
    assign acc          = valid_in && s1_free;
    assign sof_acc      = acc && sof_in;

    // The SOF beat itself already uses the freshly latched controls.
    assign sel_en   = sof_in ? filter_enable : en_q;
    assign sel_mode = sof_in ? blend_mode_e'(mode) : mode_q;

    always_comb begin
        bright_d  = bright_q;
        mode_d    = mode_q;
        en_d      = en_q;
        s1_b_d    = sof_in ? slew_b : bright_q;
        s1_mode_d = sel_en ? sel_mode : BLEND_BYPASS;
        if (sof_acc) begin
            bright_d = slew_b;
            mode_d   = blend_mode_e'(mode);
            en_d     = filter_enable;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        pixel_blend #(.BITS(BITS)) u_blend (
            .p_i    (s1_pix_q[c*BITS +: BITS]),
            .b_i    (s1_b_q),
            .mode_i (s1_mode_q),
            .out_o  (blend_pix[c*BITS +: BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bright_q  <= '0;
            mode_q    <= BLEND_BYPASS;
            en_q      <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_pix_q  <= '0;
            s1_sof_q  <= 1'b0;
            s1_b_q    <= '0;
            s1_mode_q <= BLEND_BYPASS;
            s2_v_q    <= 1'b0;
            s2_pix_q  <= '0;
            s2_sof_q  <= 1'b0;
        end else begin
            bright_q <= bright_d;
            mode_q   <= mode_d;
            en_q     <= en_d;
            if (s1_free) begin
                s1_v_q <= valid_in;
                if (acc) begin
                    s1_pix_q  <= pix_in;
                    s1_sof_q  <= sof_in;
                    s1_b_q    <= s1_b_d;
                    s1_mode_q <= s1_mode_d;
                end
            end
            if (s2_free) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_pix_q <= blend_pix;
                    s2_sof_q <= s1_sof_q;
                end
            end
        end
    end

    assign pix_out    = s2_pix_q;
    assign sof_out    = s2_sof_q;
    assign valid_out  = s2_v_q;
    assign brightness = bright_q;

endmodule

// File: tb/tb_brightness_filter_pipe.sv
// Randomized self-checking bench for brightness_filter_pipe.
// Reference model: per-frame brightness slew plus a FIFO of expected beats.
module tb_brightness_filter_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] pix_in = '0;
    logic        sof_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        module_ready;
    logic        filter_enable = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  BPM_estimate = '0;
    logic [23:0] pix_out;
    logic        sof_out;
    logic        valid_out;
    logic        output_ready = 1'b1;
    logic [7:0]  brightness;

    brightness_filter_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .pix_in        (pix_in),
        .sof_in        (sof_in),
        .valid_in      (valid_in),
        .module_ready  (module_ready),
        .filter_enable (filter_enable),
        .mode          (mode),
        .BPM_estimate  (BPM_estimate),
        .pix_out       (pix_out),
        .sof_out       (sof_out),
        .valid_out     (valid_out),
        .output_ready  (output_ready),
        .brightness    (brightness)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          mb = 0;
    int          mmode = 0;
    int          men = 0;
    logic [24:0] q[$];
    logic        prev_stall = 1'b0;
    logic [24:0] held = '0;
    logic [23:0] got_pix = '0;

    localparam int STEP = ((1 << 8) << 8) / 200;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int target_of(input int bpm);
        int bb, t;
        bb = (bpm > 200) ? 200 : bpm;
        t = (STEP * bb) / 256;
        return (t > 255) ? 255 : t;
    endfunction

    function automatic int slew(input int b, input int t);
        if (t > b) return b + (((t - b) > 16) ? 16 : (t - b));
        if (t < b) return b - (((b - t) > 16) ? 16 : (b - t));
        return b;
    endfunction

    function automatic int blend(input int p, input int b, input int md);
        int r;
        case (md)
            1: r = (p + b) / 2;
            2: r = (p + b > 255) ? 255 : p + b;
            3: begin
                r = (p * (256 + b)) / 256;
                if (r > 255) r = 255;
            end
            default: r = p;
        endcase
        return r;
    endfunction

    // One clock: drive inputs, check, advance model, step to next negedge.
    task automatic cyc(input logic v, input logic sof, input logic en,
                       input logic [1:0] md, input logic [7:0] bpm,
                       input logic [23:0] px, input logic ordy);
        logic        exp_rdy;
        logic [24:0] e;
        logic [23:0] ep;
        int          eff;
        valid_in      = v;
        sof_in        = sof;
        filter_enable = en;
        mode          = md;
        BPM_estimate  = bpm;
        pix_in        = px;
        output_ready  = ordy;
        #1;
        exp_rdy = !(q.size() == 2 && !ordy);
        chk("ready", module_ready, exp_rdy);
        if (prev_stall) begin
            chk("hold_valid", valid_out, 1);
            chk("hold_beat", {sof_out, pix_out}, held);
        end
        prev_stall = valid_out && !ordy;
        held = {sof_out, pix_out};
        if (valid_out) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else if (ordy) begin
                e = q.pop_front();
                chk("beat", {sof_out, pix_out}, e);
                got_pix = pix_out;
            end
        end
        if (v && exp_rdy) begin
            if (sof) begin
                mb = slew(mb, target_of(int'(bpm)));
                mmode = int'(md);
                men = int'(en);
            end
            eff = men ? mmode : 0;
            for (int c = 0; c < 3; c++)
                ep[c*8 +: 8] = 8'(blend(int'(px[c*8 +: 8]), mb, eff));
            q.push_back({sof, ep});
        end
        @(posedge clk);
        @(negedge clk);
        chk("brightness", brightness, mb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 8'd0, 24'd0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_sof", sof_out, 0);
        chk("rst_pix", pix_out, 0);
        chk("rst_bright", brightness, 0);
        reset = 1'b1;
        #1;
        chk("rst_ready", module_ready, 1);
        q.delete();
        mb = 0;
        mmode = 0;
        men = 0;
        prev_stall = 1'b0;
    endtask

    localparam logic [23:0] PX = {8'd0, 8'd200, 8'd100};

    initial begin
        int exp_b;
        do_reset();

        for (int k = 0; k < 10; k++) begin
            cyc(1, 1, 1, 2'd1, 8'd100, 24'($urandom), 1);
            exp_b = (16 * (k + 1) > 127) ? 127 : 16 * (k + 1);
            chk("ramp", brightness, exp_b);
        end
        idle(3);

        cyc(1, 1, 1, 2'd1, 8'd100, PX, 1);
        chk("lat_s1", valid_out, 0);
        idle(1);
        chk("lat_s2", valid_out, 1);
        idle(1);
        chk("avg", got_pix, {8'd63, 8'd163, 8'd113});

        cyc(1, 1, 1, 2'd2, 8'd100, PX, 1);
        idle(2);
        chk("sat", got_pix, {8'd127, 8'd255, 8'd227});

        cyc(1, 1, 1, 2'd3, 8'd100, PX, 1);
        idle(2);
        chk("gain", got_pix, {8'd0, 8'd255, 8'd149});

        cyc(1, 1, 1, 2'd1, 8'd100, 24'h123456, 1);
        cyc(1, 0, 1, 2'd2, 8'd100, PX, 1);
        idle(2);
        chk("midframe_mode", got_pix, {8'd63, 8'd163, 8'd113});

        cyc(1, 1, 0, 2'd3, 8'd100, PX, 1);
        idle(2);
        chk("disabled", got_pix, PX);

        cyc(1, 1, 1, 2'd1, 8'd255, PX, 1);
        chk("bpm_clamp", brightness, 143);
        cyc(1, 0, 1, 2'd1, 8'd0, PX, 1);
        chk("frozen", brightness, 143);
        cyc(1, 1, 1, 2'd1, 8'd0, PX, 1);
        chk("bpm_zero", brightness, 127);
        idle(3);

        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 2'd2, 8'd100, 24'($urandom), 0);
            chk("stall_ready", module_ready, (i == 0) ? 1 : 0);
        end
        idle(4);
        chk("stall_drain", q.size(), 0);

        cyc(1, 1, 1, 2'd3, 8'd150, 24'($urandom), 0);
        cyc(1, 0, 1, 2'd3, 8'd150, 24'($urandom), 0);
        cyc(1, 0, 1, 2'd3, 8'd150, 24'($urandom), 0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 5) == 0),
                logic'($urandom_range(0, 4) != 0),
                2'($urandom),
                8'($urandom),
                24'($urandom),
                logic'($urandom_range(0, 9) < 7));
        end
        idle(4);
        chk("final_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brightness_filter_pipe.md
# brightness_filter_pipe

Parametrised, pipelined successor to the single-channel pixel brightness filter. It applies a BPM-driven brightness offset or gain to CHANNELS parallel pixel components per beat. It supports four selectable blend modes and slews brightness toward its target once per frame, so BPM jumps do not flicker. It sits in the pixel-wise parallel filter chain between the video source and downstream filters, using a full valid/ready stream handshake with backpressure.

## Interface
- BITS, 8: bit depth per channel component.
- CHANNELS, 3: components per beat (e.g. R,G,B).
- MAX_BPM, 200: BPM that maps to full-scale brightness.
- RAMP_STEP, 16: maximum brightness change per frame, in LSBs of BITS.
- STEP_SIZE, ((1<<BITS)<<8)/MAX_BPM: Q8 brightness-per-BPM; 327 at defaults.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- pix_in  in  CHANNELS*BITS  channel c occupies bits [c*BITS +: BITS].
- sof_in  in  1  marks the first beat of a frame; qualified by valid_in.
- valid_in  in  1  input beat valid.
- module_ready  out  1  block can accept a beat this cycle.
- filter_enable  in  1  0 = pass-through; sampled on the SOF beat.
- mode  in  2  0 bypass, 1 average, 2 saturating add, 3 gain; sampled on the SOF beat.
- BPM_estimate  in  $clog2(MAX_BPM+1)  heart-rate estimate; values above MAX_BPM are clamped to MAX_BPM.
- pix_out  out  CHANNELS*BITS  filtered beat.
- sof_out  out  1  SOF delayed alongside its beat.
- valid_out  out  1  output beat valid.
- output_ready  in  1  downstream accepts a beat.
- brightness  out  BITS  current (slewed) brightness applied to pixels.

## Operation
- Target brightness: target = min(2^BITS-1, (STEP_SIZE*min(BPM,MAX_BPM))>>8). Compute the product at full width (STEP_SIZE width + BPM width) with no truncation before the shift.
- Slew register `brightness`, reset value 0. On an accepted beat with sof_in=1:
  - Move brightness toward target by min(RAMP_STEP, |target−brightness|).
  - That beat and the rest of the frame use the new value.
  - Between SOF beats, brightness is frozen even if BPM changes.
- Latch mode and filter_enable on the same SOF beat; they stay constant for the frame. The reset value of the latched mode is 0 (bypass) and of the latched enable is 0.
- Per-channel arithmetic (p = component, b = brightness, M = 2^BITS−1):
  - bypass, or enable=0: out = p.
  - average: out = (p + b) >> 1, computed at BITS+1 bits.
  - saturating add: out = min(M, p + b).
  - gain: out = min(M, (p*(2^BITS + b)) >> BITS), with the product computed at 2*BITS+1 bits.
- All channels use the same b and mode within a beat.

## Timing
- Two register stages:
  - S1 registers the input beat together with the slew-updated brightness and mode.
  - S2 registers the blended result.
- Latency is 2 cycles from the accept edge to valid_out with no stalls.
- Throughput is one beat per cycle.
- Handshake: a beat transfers when valid && ready are both high at a clock edge.
- module_ready = !(S1 full && S2 full && !output_ready). It is combinational from the internal valid registers and output_ready only, never from valid_in.
- Output hold: while valid_out=1 && output_ready=0, pix_out and sof_out are held stable. No beat is dropped or duplicated.
- Reset (reset=0 at an edge): valid_out, sof_out and pix_out go to 0, and brightness goes to 0. This applies mid-frame too; in-flight beats are discarded. module_ready is 1 in the first cycle after reset deasserts.
- SOF beat during a stall: the slew update happens only on the accept edge, never on a cycle where the beat is merely presented.
- Consecutive SOF beats (1-beat frames): each SOF applies one slew step.
- Target equal to brightness: no change. The slew never overshoots the target.

## Structure
- Shared package `pixel_filter_pkg`:
  - `blend_mode_e` enum {BLEND_BYPASS, BLEND_AVG, BLEND_SAT_ADD, BLEND_GAIN}.
  - Function `bpm_to_brightness(bpm)` for the target formula.
- Sub-module `pixel_blend`: purely combinational, one channel (p, b, mode → out). It is instantiated CHANNELS times with a generate loop.
- The top level holds the slew register, the mode/enable latch, and the two-stage valid/ready pipeline.

## Test plan
- Defaults, BPM=100 held, RAMP_STEP=16, one-beat frames with SOF=1 each beat. Required:
  - target = 127;
  - brightness sequence 16, 32, …, 112, 127;
  - thereafter 127 for every frame.
- brightness=127 in steady state, pixel components {100, 200, 0}:
  - average → {113, 163, 63};
  - saturating add → {227, 255, 127};
  - gain → {149, 255, 0}.
- Change mode mid-frame from 1 to 2 on a non-SOF beat → output stays in average mode until the next SOF beat.
- BPM=255 (above MAX_BPM) → target clamps to 255; BPM=0 → target 0, slewing down 16 per frame.
- Hold output_ready=0 for 5 cycles under continuous valid_in. Required:
  - module_ready falls after 2 beats are buffered;
  - pix_out is held stable;
  - after release, all beats emerge in order, none lost or duplicated.
- Assert reset=0 mid-frame with both stages full → next cycle valid_out=0, brightness=0, module_ready=1 after release.
